// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ ports.
// Optional idle-grant timeout: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NREQ       = 4,
  parameter int TMO_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_wr,
  input  logic [NREQ-1:0]   req_last,
  input  logic [8*NREQ-1:0] req_din,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              tmo,
  input  logic              u_ready,
  output logic              u_wr,
  output logic [7:0]        u_din
);

  localparam int OW = $clog2(NREQ);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [NREQ-1:0] grant_nxt;
  logic            busy_nxt;
  logic [OW-1:0]   owner;
  logic [OW-1:0]   owner_nxt;
  logic [OW-1:0]   rr;
  logic [OW-1:0]   rr_nxt;

  logic            lock;
  logic            own_req;
  logic            own_wr;
  logic            own_last;
  logic [7:0]      own_din;
  logic            win_found;
  logic [OW-1:0]   win;
  logic            acc;
  logic            tmo_hit;
  logic            rel;

  assign lock = (state == LOCK);

  // Select the owner's request lines.
  always_comb begin
    own_req  = 1'b0;
    own_wr   = 1'b0;
    own_last = 1'b0;
    own_din  = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == OW'(i)) begin
        own_req  = req[i];
        own_wr   = req_wr[i];
        own_last = req_last[i];
        own_din  = req_din[8*i +: 8];
      end
    end
  end

  // Rotating priority search: ports rr..NREQ-1 first, then 0..rr-1.
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && req[i] && (OW'(i) >= rr)) begin
        win_found = 1'b1;
        win       = OW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && req[i] && (OW'(i) < rr)) begin
        win_found = 1'b1;
        win       = OW'(i);
      end
    end
  end

  // Combinational data path from owner to UART.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = lock && (owner == OW'(i)) && u_ready;
    end
    u_wr  = lock && own_wr && u_ready;
    u_din = lock ? own_din : 8'h00;
  end

  assign acc = u_wr;

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic        tmo_q;

  // Idle counter: clears on grant and accepted bytes, saturates.
  always_comb begin
    cnt_nxt = '0;
    tmo_hit = 1'b0;
    if (lock && !acc) begin
      cnt_nxt = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
      tmo_hit = (32'(cnt_nxt) >= TMO_CYCLES);
    end
  end

  // Register idle counter and timeout pulse.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      cnt   <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      tmo_q <= tmo_hit;
    end
  end

  assign tmo = tmo_q;
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(TMO_CYCLES);
  assign tmo_hit    = 1'b0;
  assign tmo        = 1'b0;
`endif

  assign rel = (acc && own_last) || (!own_req && !acc) || tmo_hit;

  // Next-state logic: arbitrate in IDLE, release in LOCK.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    busy_nxt  = busy;
    owner_nxt = owner;
    rr_nxt    = rr;
    unique case (state)
      IDLE: begin
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        if (win_found) begin
          state_nxt = LOCK;
          owner_nxt = win;
          busy_nxt  = 1'b1;
          for (int i = 0; i < NREQ; i++) begin
            grant_nxt[i] = (win == OW'(i));
          end
        end
      end
      LOCK: begin
        if (rel) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          busy_nxt  = 1'b0;
          rr_nxt    = (owner == OW'(NREQ-1)) ? '0
                                             : owner + OW'(1);
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state <= IDLE;
      grant <= '0;
      busy  <= 1'b0;
      owner <= '0;
      rr    <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      busy  <= busy_nxt;
      owner <= owner_nxt;
      rr    <= rr_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter.
// Reference model: modular round-robin pointer plus byte scoreboard.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 20;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int STALL = 15;
`else
  localparam int STALL = 100;
`endif

  logic         clk = 1'b0;
  logic         arstn;
  logic [N-1:0] req;
  logic [N-1:0] req_wr;
  logic [N-1:0] req_last;
  logic [8*N-1:0] req_din;
  logic [N-1:0] req_ready;
  logic [N-1:0] grant;
  logic         busy;
  logic         tmo;
  logic         u_ready;
  logic         u_wr;
  logic [7:0]   u_din;

  int checks = 0;
  int errors = 0;
  int rr_m;
  int wr_count;
  logic [7:0] mon_q[$];
  logic [7:0] exp_q[$];

  uart_tx_arbiter #(.NREQ(N), .TMO_CYCLES(TMO)) dut (
    .clk(clk), .arstn(arstn),
    .req(req), .req_wr(req_wr),
    .req_last(req_last), .req_din(req_din),
    .req_ready(req_ready), .grant(grant),
    .busy(busy), .tmo(tmo),
    .u_ready(u_ready), .u_wr(u_wr), .u_din(u_din)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (arstn && u_wr) begin
      wr_count++;
      mon_q.push_back(u_din);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr_inputs();
    req      = '0;
    req_wr   = '0;
    req_last = '0;
    req_din  = '0;
    u_ready  = 1'b0;
  endtask

  task automatic do_reset();
    clr_inputs();
    arstn = 1'b0;
    tick();
    tick();
    arstn = 1'b1;
    rr_m = 0;
    wr_count = 0;
    mon_q.delete();
    exp_q.delete();
  endtask

  function automatic int winner(int ptr, logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(int p);
    logic [N-1:0] v;
    v = '0;
    if (p >= 0) v[p] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    clr_inputs();
    arstn   = 1'b0;
    req     = '1;
    req_wr  = '1;
    req_last = '1;
    req_din = $urandom;
    u_ready = 1'b1;
    #2;
    checks++;
    if (grant !== '0 || busy !== 1'b0 || tmo !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: grant=%b busy=%b tmo=%b expected 0",
               grant, busy, tmo);
    end
    checks++;
    if (req_ready !== '0 || u_wr !== 1'b0 || u_din !== 8'h00) begin
      errors++;
      $display("FAIL reset_comb: ready=%b u_wr=%b u_din=%h expected 0",
               req_ready, u_wr, u_din);
    end
    do_reset();
    req = 4'b0001;
    tick();
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL reset_pre_grant: grant=%b expected 0001", grant);
    end
    req_wr[0] = 1'b1;
    req_din[7:0] = 8'h5A;
    u_ready = 1'b1;
    #2;
    arstn = 1'b0;
    #1;
    checks++;
    if (grant !== '0 || busy !== 1'b0 || u_wr !== 1'b0 ||
        req_ready !== '0) begin
      errors++;
      $display("FAIL reset_mid_msg: grant=%b busy=%b u_wr=%b ready=%b expected 0",
               grant, busy, u_wr, req_ready);
    end
    tick();
    arstn = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] b[3];
    b[0] = 8'h41;
    b[1] = 8'h42;
    b[2] = 8'h43;
    do_reset();
    req = 4'b0001;
    settle();
    checks++;
    if (grant !== '0) begin
      errors++;
      $display("FAIL single_no_early_grant: grant=%b expected 0000", grant);
    end
    tick();
    checks++;
    if (grant !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: grant=%b busy=%b expected 0001 1",
               grant, busy);
    end
    for (int j = 0; j < 3; j++) begin
      req_wr[0]    = 1'b1;
      req_din[7:0] = b[j];
      req_last[0]  = (j == 2);
      u_ready      = 1'b0;
      settle();
      checks++;
      if (u_wr !== 1'b0 || req_ready !== '0) begin
        errors++;
        $display("FAIL single_hold%0d: u_wr=%b ready=%b expected 0 0000",
                 j, u_wr, req_ready);
      end
      tick();
      u_ready = 1'b1;
      settle();
      checks++;
      if (u_wr !== 1'b1 || u_din !== b[j] || req_ready !== 4'b0001) begin
        errors++;
        $display("FAIL single_byte%0d: u_wr=%b u_din=%h ready=%b expected 1 %h 0001",
                 j, u_wr, u_din, req_ready, b[j]);
      end
      tick();
      if (j < 2) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL single_busy%0d: busy=%b expected 1", j, busy);
        end
      end
    end
    req    = '0;
    req_wr = '0;
    u_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || grant !== '0) begin
      errors++;
      $display("FAIL single_release: busy=%b grant=%b expected 0 0000",
               busy, grant);
    end
    checks++;
    if (mon_q.size() != 3 || mon_q[0] !== b[0] || mon_q[1] !== b[1] ||
        mon_q[2] !== b[2]) begin
      errors++;
      $display("FAIL single_stream: got %0d bytes expected 41 42 43",
               mon_q.size());
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] d[N];
    int e;
    do_reset();
    req = '1;
    u_ready = 1'b1;
    tick();
    for (int m = 0; m < 5; m++) begin
      e = winner(rr_m, req);
      checks++;
      if (grant !== onehot(e) || busy !== 1'b1) begin
        errors++;
        $display("FAIL rr_grant%0d: grant=%b expected %b", m, grant, onehot(e));
      end
      for (int p = 0; p < N; p++) begin
        d[p] = 8'($urandom);
        req_din[8*p +: 8] = d[p];
      end
      req_wr   = '1;
      req_last = '1;
      settle();
      checks++;
      if (u_wr !== 1'b1 || u_din !== d[e] || req_ready !== onehot(e)) begin
        errors++;
        $display("FAIL rr_byte%0d: u_wr=%b u_din=%h ready=%b expected 1 %h %b",
                 m, u_wr, u_din, req_ready, d[e], onehot(e));
      end
      tick();
      rr_m = (e + 1) % N;
      req_wr = '0;
      settle();
      checks++;
      if (grant !== '0 || busy !== 1'b0 || u_wr !== 1'b0) begin
        errors++;
        $display("FAIL rr_idle%0d: grant=%b busy=%b u_wr=%b expected 0",
                 m, grant, busy, u_wr);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] d;
    int bad;
    int base;
    do_reset();
    req = 4'b0001;
    tick();
    d = 8'($urandom);
    req_wr[0]    = 1'b1;
    req_din[7:0] = d;
    req_last[0]  = 1'b0;
    u_ready      = 1'b0;
    bad = 0;
    base = wr_count;
    for (int c = 0; c < STALL; c++) begin
      settle();
      if (u_wr !== 1'b0 || req_ready !== '0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_stall: %0d stalled cycles leaked, expected 0", bad);
    end
    u_ready = 1'b1;
    settle();
    checks++;
    if (u_wr !== 1'b1 || u_din !== d || req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL bp_accept: u_wr=%b u_din=%h ready=%b expected 1 %h 0001",
               u_wr, u_din, req_ready, d);
    end
    tick();
    req_wr = '0;
    repeat (4) tick();
    checks++;
    if (wr_count - base != 1) begin
      errors++;
      $display("FAIL bp_once: writes=%0d expected 1", wr_count - base);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_still_locked: busy=%b expected 1", busy);
    end
  endtask

  task automatic test_abort();
    int e;
    do_reset();
    req = 4'b0100;
    tick();
    checks++;
    if (grant !== 4'b0100) begin
      errors++;
      $display("FAIL abort_grant: grant=%b expected 0100", grant);
    end
    req_wr[2]      = 1'b1;
    req_din[23:16] = 8'h10;
    req_last[2]    = 1'b0;
    u_ready        = 1'b1;
    settle();
    checks++;
    if (u_wr !== 1'b1 || u_din !== 8'h10) begin
      errors++;
      $display("FAIL abort_byte: u_wr=%b u_din=%h expected 1 10", u_wr, u_din);
    end
    tick();
    req_wr = '0;
    req    = 4'b1001;
    tick();
    rr_m = 3;
    checks++;
    if (busy !== 1'b0 || grant !== '0) begin
      errors++;
      $display("FAIL abort_release: busy=%b grant=%b expected 0 0000",
               busy, grant);
    end
    req = 4'b1101;
    tick();
    e = winner(rr_m, req);
    checks++;
    if (grant !== onehot(e)) begin
      errors++;
      $display("FAIL abort_next: grant=%b expected %b", grant, onehot(e));
    end
  endtask

  task automatic test_isolation();
    logic [7:0] pb[4];
    logic       ew;
    int j;
    int cyc;
    do_reset();
    for (int k = 0; k < 4; k++) pb[k] = 8'($urandom);
    req = 4'b0001;
    tick();
    req = 4'b0011;
    j = 0;
    cyc = 0;
    while (j < 4 && cyc < 60) begin
      u_ready        = 1'($urandom);
      req_wr[0]      = 1'($urandom);
      req_din[7:0]   = pb[j];
      req_last[0]    = (j == 3);
      req_wr[1]      = ~req_wr[1];
      req_din[15:8]  = 8'hFF;
      req_last[1]    = 1'b1;
      ew = req_wr[0] & u_ready;
      settle();
      checks++;
      if (u_wr !== ew || req_ready[1] !== 1'b0 ||
          req_ready[0] !== u_ready || (ew && u_din !== pb[j])) begin
        errors++;
        $display("FAIL iso_cycle%0d: u_wr=%b u_din=%h ready=%b expected %b %h",
                 cyc, u_wr, u_din, req_ready, ew, pb[j]);
      end
      tick();
      if (ew) j++;
      cyc++;
    end
    checks++;
    if (j != 4) begin
      errors++;
      $display("FAIL iso_budget: sent=%0d expected 4", j);
    end
    req_wr = '0;
    checks++;
    if (grant !== '0) begin
      errors++;
      $display("FAIL iso_release: grant=%b expected 0000", grant);
    end
    tick();
    checks++;
    if (grant !== 4'b0010) begin
      errors++;
      $display("FAIL iso_next: grant=%b expected 0010", grant);
    end
    checks++;
    if (mon_q.size() != 4 || mon_q[0] !== pb[0] || mon_q[1] !== pb[1] ||
        mon_q[2] !== pb[2] || mon_q[3] !== pb[3]) begin
      errors++;
      $display("FAIL iso_stream: got %0d bytes expected 4 port0 bytes",
               mon_q.size());
    end
  endtask

  task automatic test_random();
    int pending[N];
    logic [N-1:0] reqm;
    logic [7:0] msg[4];
    int e, len, ab, j, cyc, nmsg, bad;
    logic wr, acc, done;
    do_reset();
    for (int p = 0; p < N; p++) pending[p] = $urandom_range(2, 5);
    nmsg = 0;
    bad = 0;
    while (nmsg < 60) begin
      reqm = '0;
      for (int p = 0; p < N; p++) reqm[p] = (pending[p] > 0);
      if (reqm == '0) break;
      req = reqm;
      req_wr = '0;
      tick();
      e = winner(rr_m, reqm);
      checks++;
      if (grant !== onehot(e) || busy !== 1'b1) begin
        errors++;
        $display("FAIL rnd_grant%0d: grant=%b expected %b", nmsg, grant, onehot(e));
      end
      len = $urandom_range(1, 4);
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1;
      for (int k = 0; k < 4; k++) msg[k] = 8'($urandom);
      j = 0;
      cyc = 0;
      done = 1'b0;
      while (!done && cyc < 200) begin
        if (j == ab) begin
          req[e]  = 1'b0;
          req_wr  = '0;
          u_ready = 1'($urandom);
          settle();
          if (u_wr !== 1'b0) bad++;
          tick();
          done = 1'b1;
        end else begin
          u_ready  = ($urandom_range(0, 3) != 0);
          wr       = ($urandom_range(0, 3) != 0);
          req_wr   = N'($urandom);
          req_last = N'($urandom);
          req_din  = $urandom;
          req_wr[e]   = wr;
          req_last[e] = (j == len - 1);
          req_din[8*e +: 8] = msg[j];
          acc = wr & u_ready;
          settle();
          if (u_wr !== acc || req_ready !== (u_ready ? onehot(e) : '0) ||
              (acc && u_din !== msg[j])) begin
            bad++;
            $display("FAIL rnd_cycle: msg=%0d u_wr=%b u_din=%h ready=%b expected %b %h",
                     nmsg, u_wr, u_din, req_ready, acc, msg[j]);
          end
          tick();
          if (acc) begin
            exp_q.push_back(msg[j]);
            j++;
            if (j == len) done = 1'b1;
          end
        end
        cyc++;
      end
      checks++;
      if (!done) begin
        errors++;
        $display("FAIL rnd_budget%0d: message did not complete", nmsg);
      end
      req_wr = '0;
      checks++;
      if (busy !== 1'b0 || grant !== '0) begin
        errors++;
        $display("FAIL rnd_release%0d: busy=%b grant=%b expected 0", nmsg,
                 busy, grant);
      end
      rr_m = (e + 1) % N;
      pending[e]--;
      nmsg++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rnd_datapath: %0d bad cycles expected 0", bad);
    end
    checks++;
    if (mon_q.size() != exp_q.size() || mon_q != exp_q) begin
      errors++;
      $display("FAIL rnd_stream: got %0d bytes expected %0d (or content differs)",
               mon_q.size(), exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int bad;
    do_reset();
    req = 4'b0001;
    tick();
    bad = 0;
`ifdef UART_ARB_TIMEOUT_EN
    for (int c = 1; c <= 21; c++) begin
      u_ready = 1'($urandom);
      tick();
      if (c < 20) begin
        if (busy !== 1'b1 || tmo !== 1'b0) bad++;
      end else if (c == 20) begin
        checks++;
        if (tmo !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL tmo_fire: tmo=%b busy=%b expected 1 0", tmo, busy);
        end
      end else begin
        checks++;
        if (tmo !== 1'b0) begin
          errors++;
          $display("FAIL tmo_pulse: tmo=%b expected 0", tmo);
        end
      end
    end
`else
    for (int c = 1; c <= 40; c++) begin
      u_ready = 1'($urandom);
      tick();
      if (busy !== 1'b1 || tmo !== 1'b0) bad++;
    end
`endif
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL tmo_hold: %0d cycles with wrong busy/tmo", bad);
    end
  endtask

  initial begin
    arstn = 1'b0;
    clr_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_abort();
    test_isolation();
    test_random();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
